// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit with HI/LO registers and a busy/done handshake.
// Optional macro MULDIV_UNSIGNED_EN adds multu (0x19) and divu (0x1B).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               is_mul;
  logic               is_div;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MULDIV_UNSIGNED_EN
  assign is_mul    = (funct == F_MULT) || (funct == 6'h19);
  assign is_div    = (funct == F_DIV)  || (funct == 6'h1B);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
`else
  assign is_mul    = (funct == F_MULT);
  assign is_div    = (funct == F_DIV);
  assign is_signed = 1'b1;
`endif

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign mag_a = a_neg ? (~a + 1'b1) : a;
  assign mag_b = b_neg ? (~b + 1'b1) : b;

  // Mult: acc holds {partial product, remaining multiplier bits}, shifted right.
  // Div: acc holds {partial remainder, remaining dividend / growing quotient}, shifted left.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = acc[2*WIDTH-1:WIDTH-1];
    diff     = trial - {1'b0, opnd};
    q_bit    = ~diff[WIDTH];
    acc_step = {sum, acc[WIDTH-1:1]};
    if (op_div) begin
      acc_step = {(q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    end
  end

  always_comb begin
    prod   = neg_q ? (~acc + 1'b1) : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_div) begin
      fix_lo = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      fix_hi = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still belongs to the completing op, so requests wait one cycle.
          if (start && !done) begin
            if (funct == F_MTHI) begin
              hi <= a;
            end else if (funct == F_MTLO) begin
              lo <= a;
            end else if (is_mul || is_div) begin
              op_div <= is_div;
              busy   <= 1'b1;
              cnt    <= '0;
              if (is_div && (b == '0)) begin
                // Divide by zero: preload the fixed result and skip the iterations.
                acc   <= {a, {WIDTH{1'b1}}};
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= FIX;
              end else begin
                opnd  <= is_div ? mag_b : mag_a;
                acc   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                state <= RUN;
              end
            end
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, directed corner sequences and
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic; SV / and % truncate toward zero.
  task automatic model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] eh, output logic [31:0] el, output int edges);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    edges = 34;
    eh = 0;
    el = 0;
    case (f)
      6'h18: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      6'h19: begin up = {32'h0, av} * {32'h0, bv}; eh = up[63:32]; el = up[31:0]; end
      6'h1A, 6'h1B: begin
        if (bv == 0) begin
          eh = av; el = 32'hFFFF_FFFF; edges = 2;
        end else if (f == 6'h1A) begin
          q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0];
        end else begin
          eh = av % bv; el = av / bv;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        output int edges, output int busy_cnt, output bit got);
    @(negedge clk);
    start = 1'b1; funct = f; a = av; b = bv;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && edges < 60) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
  endtask

  task automatic do_check_op(input string tag, input logic [5:0] f, input logic [31:0] av,
                             input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                             input int exp_edges);
    int  edges, bc;
    bit  got;
    run_op(f, av, bv, edges, bc, got);
    check({tag, " done"}, 64'(got), 64'd1);
    check({tag, " edges"}, 64'(edges), 64'(exp_edges));
    check({tag, " busy_cycles"}, 64'(bc), 64'(exp_edges - 1));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    $display("op %s funct=%0h a=%08h b=%08h -> hi=%08h lo=%08h edges=%0d", tag, f, av, bv, hi, lo, edges);
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] av);
    @(negedge clk);
    start = 1'b1; funct = f; a = av; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] eh, el, ph, pl, ra, rb;
    logic [5:0]  rf;
    int          ee, edges, bc;
    bit          got, seen;

    vecs[0]  = '{6'h18, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{6'h1A, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2]  = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[3]  = '{6'h1A, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[4]  = '{6'h1A, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
    vecs[5]  = '{6'h18, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[6]  = '{6'h1A, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3};
    vecs[7]  = '{6'h1A, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8]  = '{6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[9]  = '{6'h1A, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{6'h18, 32'h0,         32'hFFFF_FFFF, 32'h0,         32'h0};

    rst_n = 1'b0; start = 1'b0; funct = 6'h0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_check_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                  (vecs[i].f == 6'h1A && vecs[i].b == 0) ? 2 : 34);
    end

    // mthi / mtlo never raise busy
    move_to(6'h11, 32'hAAAA_0000);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi hi", 64'(hi), 64'hAAAA_0000);
    move_to(6'h13, 32'h0000_5555);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo hi", 64'(hi), 64'hAAAA_0000);
    check("mtlo lo", 64'(lo), 64'h5555);
    move_to(6'h2A, 32'h1357_9BDF);
    check("unknown hi", 64'(hi), 64'hAAAA_0000);
    check("unknown lo", 64'(lo), 64'h5555);
    $display("op mthi/mtlo -> hi=%08h lo=%08h", hi, lo);

    // mtlo while busy is ignored
    @(negedge clk);
    start = 1'b1; funct = 6'h18; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    move_to(6'h13, 32'h1);
    check("busy reject lo", 64'(lo), 64'h5555);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1; else @(negedge clk);
    end
    check("busy reject done", 64'(seen), 64'd1);
    check("busy reject hi", 64'(hi), 64'd0);
    check("busy reject lo final", 64'(lo), 64'd25);
    $display("op mult 5*5 with mtlo while busy -> hi=%08h lo=%08h", hi, lo);

    // start during the done cycle waits one cycle
    @(negedge clk);
    start = 1'b1; funct = 6'h18; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1; else @(negedge clk);
    end
    check("done-cycle op done", 64'(seen), 64'd1);
    start = 1'b1; funct = 6'h11; a = 32'hCAFE_0001;
    @(negedge clk);
    check("done-cycle mthi held off", 64'(hi), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("done-cycle mthi next", 64'(hi), 64'hCAFE_0001);
    check("done-cycle lo", 64'(lo), 64'd12);
    $display("op mthi during done -> hi=%08h lo=%08h", hi, lo);

`ifdef MULDIV_UNSIGNED_EN
    do_check_op("multu", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34);
    do_check_op("divu", 6'h1B, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'h7FFF_FFFF, 34);
    do_check_op("divu0", 6'h1B, 32'h8000_0001, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF, 2);
`else
    ph = hi; pl = lo;
    @(negedge clk);
    start = 1'b1; funct = 6'h19; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    funct = 6'h1B;
    @(negedge clk);
    start = 1'b0;
    check("multu off busy", 64'(busy), 64'd0);
    repeat (36) @(negedge clk);
    check("multu off hi", 64'(hi), 64'(ph));
    check("multu off lo", 64'(lo), 64'(pl));
    check("multu off done", 64'(done), 64'd0);
    $display("op multu/divu disabled -> hi=%08h lo=%08h", hi, lo);
`endif

    // randomized operations against the model
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: rf = 6'h18;
        1: rf = 6'h1A;
`ifdef MULDIV_UNSIGNED_EN
        2: rf = 6'h19;
        default: rf = 6'h1B;
`else
        default: rf = ($urandom_range(0, 1) != 0) ? 6'h18 : 6'h1A;
`endif
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) != 0) ra = ra >>> $urandom_range(0, 31);
      model(rf, ra, rb, eh, el, ee);
      do_check_op($sformatf("rnd%0d", i), rf, ra, rb, eh, el, ee);
    end

    // asynchronous reset in the middle of a mult
    move_to(6'h11, 32'h0BAD_0BAD);
    @(negedge clk);
    start = 1'b1; funct = 6'h18; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("post rst no done", 64'(seen), 64'd0);
    check("post rst hi", 64'(hi), 64'd0);
    check("post rst lo", 64'(lo), 64'd0);
    $display("op reset mid-run -> hi=%08h lo=%08h", hi, lo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
